// File: rtl/avalon_bram_burst_pkg.sv
// Shared types and helpers for the burst-capable Avalon-MM BlockRAM agent.
package avalon_bram_pkg;

   typedef enum logic [1:0] {RESET, IDLE, WR_BURST, RD_BURST} bram_state_t;

   function automatic int lanes(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int lane_bits(input int data_w);
      return (data_w <= 8) ? 0 : $clog2(data_w / 8);
   endfunction

   // burstcount 0 means a single beat; anything beyond the maximum is clamped.
   function automatic int clamp_burst(input int count, input int burstcount_w);
      int max_burst;
      max_burst = 1 << (burstcount_w - 1);
      if (count == 0) return 1;
      if (count > max_burst) return max_burst;
      return count;
   endfunction

endpackage

// File: rtl/avalon_bram_burst_lane.sv
// One 8-bit lane of the BlockRAM: synchronous write, registered read that holds
// its last value when no read is issued.
module bram_byte_lane
   import avalon_bram_pkg::*;
#(
   parameter int RAM_ADD_W = 11
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [RAM_ADD_W-1:0] addr,
   input  logic                 we,
   input  logic                 re,
   input  logic [7:0]           din,
   output logic [7:0]           dout
);

   logic [7:0] mem [2**RAM_ADD_W];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= din;
   end

   // Output register is cleared by reset; the array contents are not.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  dout <= '0;
      else if (re)   dout <= mem[addr];
   end

endmodule

// File: rtl/avalon_bram_burst.sv
// Avalon-MM agent BlockRAM with byte-lane writes and counter-driven burst reads/writes.
module avalon_bram_burst
   import avalon_bram_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int RAM_ADD_W    = 11,
   parameter int BURSTCOUNT_W = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [31:0]             address,
   input  logic                    read,
   input  logic                    write,
   input  logic [DATA_W/8-1:0]     byteenable,
   input  logic [DATA_W-1:0]       writedata,
   input  logic [BURSTCOUNT_W-1:0] burstcount,
   output logic [DATA_W-1:0]       readdata,
   output logic                    readdatavalid,
   output logic                    waitrequest
);

   localparam int LANES = lanes(DATA_W);
   localparam int LB    = lane_bits(DATA_W);

   bram_state_t             state_q, state_d;
   logic [RAM_ADD_W-1:0]    cnt_q, cnt_d;
   logic [BURSTCOUNT_W-1:0] rem_q, rem_d;
   logic                    wait_d, rdv_d;
   logic [RAM_ADD_W-1:0]    index;
   logic [BURSTCOUNT_W-1:0] burst_len;
   logic [RAM_ADD_W-1:0]    ram_addr_p0;
   logic                    ram_wr_p0, ram_re_p0;
   logic [LANES-1:0]        lane_we_p0;
   logic                    unused_address;

   assign index          = address[RAM_ADD_W+LB-1:LB];
   assign unused_address = ^address;
   assign burst_len      = BURSTCOUNT_W'(clamp_burst(int'(burstcount), BURSTCOUNT_W));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      wait_d      = waitrequest;
      rdv_d       = 1'b0;
      ram_addr_p0 = cnt_q;
      ram_wr_p0   = 1'b0;
      ram_re_p0   = 1'b0;
      case (state_q)
         RESET: begin
            state_d = IDLE;
            wait_d  = 1'b0;
         end
         IDLE: begin
            wait_d      = 1'b0;
            ram_addr_p0 = index;
            // A write wins over a simultaneous read; the read is dropped.
            if (write) begin
               ram_wr_p0 = 1'b1;
               cnt_d     = index + 1'b1;
               rem_d     = burst_len - 1'b1;
               if (burst_len != BURSTCOUNT_W'(1)) state_d = WR_BURST;
            end else if (read) begin
               ram_re_p0 = 1'b1;
               cnt_d     = index + 1'b1;
               rem_d     = burst_len - 1'b1;
               rdv_d     = 1'b1;
               wait_d    = 1'b1;
               state_d   = RD_BURST;
            end
         end
         WR_BURST: begin
            if (write) begin
               ram_wr_p0 = 1'b1;
               cnt_d     = cnt_q + 1'b1;
               rem_d     = rem_q - 1'b1;
               if (rem_q == BURSTCOUNT_W'(1)) state_d = IDLE;
            end
         end
         RD_BURST: begin
            // rem_q counts beats still to be issued after the first one.
            if (rem_q != '0) begin
               ram_re_p0 = 1'b1;
               cnt_d     = cnt_q + 1'b1;
               rem_d     = rem_q - 1'b1;
               rdv_d     = 1'b1;
               wait_d    = 1'b1;
            end else begin
               wait_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = RESET;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= RESET;
         cnt_q         <= '0;
         rem_q         <= '0;
         waitrequest   <= 1'b1;
         readdatavalid <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rem_q         <= rem_d;
         waitrequest   <= wait_d;
         readdatavalid <= rdv_d;
      end
   end

   // ---- stage p0 -> p1: RAM access, registered readdata per lane ----
   assign lane_we_p0 = {LANES{ram_wr_p0}} & byteenable;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      bram_byte_lane #(.RAM_ADD_W(RAM_ADD_W)) u_lane (
         .clk     (clk),
         .reset_n (reset_n),
         .addr    (ram_addr_p0),
         .we      (lane_we_p0[g]),
         .re      (ram_re_p0),
         .din     (writedata[8*g +: 8]),
         .dout    (readdata[8*g +: 8])
      );
   end

   assert property (@(posedge clk) disable iff (!reset_n) !(state_q == IDLE && read && write));
   assert property (@(posedge clk) disable iff (!reset_n) !(state_q == WR_BURST && read));

endmodule
